// File: rtl/sb_pkg.sv
// sb_pkg: shared sizing for the register scoreboard.
package sb_pkg;
  localparam int AW = 5;
  localparam int NREG = 32;
  localparam int CW = 2;
  localparam int MAXC = (1 << CW) - 1;
  function automatic int fsw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sb_entry.sv
// sb_entry: one register's outstanding-write counter with underflow clamp.
module sb_entry #(
  parameter int CW = 2,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          inc,
  input  logic [DW-1:0] ndec,
  output logic [CW-1:0] cnt,
  output logic          uf
);
  localparam int W = (CW > DW ? CW : DW) + 1;
  logic [W-1:0] s, d;
  assign s = W'(cnt) + W'(inc);
  assign d = W'(ndec);
  assign uf = !flush && (d > s);
  always_ff @(posedge clk) begin
    if (reset || flush) cnt <= '0;
    else cnt <= uf ? '0 : CW'(s - d);
  end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write tracker for decode issue.
// Define SB_FWD_EN to let count==1 sources issue off a matching forward port.
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int NSRC = 2,
  parameter int NWB  = 2,
  parameter int NFWD = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     iss_valid,
  output logic                     iss_ready,
  input  logic [NSRC-1:0]          iss_src_use,
  input  logic [NSRC*AW-1:0]       iss_src_addr,
  input  logic                     iss_dst_we,
  input  logic [AW-1:0]            iss_dst_addr,
  input  logic [NWB-1:0]           wb_valid,
  input  logic [NWB*AW-1:0]        wb_addr,
  input  logic [NFWD-1:0]          fwd_valid,
  input  logic [NFWD*AW-1:0]       fwd_addr,
  output logic [NSRC-1:0]          src_fwd_hit,
  output logic [NSRC*fsw(NFWD)-1:0] src_fwd_sel,
  output logic [NREG-1:0]          busy_vec,
  output logic                     err_underflow
);
  localparam int FW = fsw(NFWD);
  localparam int DW = $clog2(NWB + 1);
  logic [CW-1:0] cnt [2**AW];
  logic [2**AW-1:0] uf;
  logic [NSRC-1:0] ok;
  logic fire, eff_dst, m, h;
  logic [AW-1:0] a;
  logic [FW-1:0] ks;
  assign eff_dst = iss_dst_we && iss_dst_addr != '0;
  assign fire = iss_valid && iss_ready;
  assign iss_ready = !flush && &ok && !(eff_dst && cnt[iss_dst_addr] == CW'(MAXC));
  genvar r;
  generate
    for (r = 0; r < 2**AW; r++) begin : g_r
      if (r == 0 || r >= NREG) begin : g_z
        assign cnt[r] = '0;
        assign uf[r] = 1'b0;
      end else begin : g_e
        logic inc;
        logic [DW-1:0] ndec;
        always_comb begin
          inc = fire && iss_dst_we && iss_dst_addr == AW'(r);
          ndec = '0;
          for (int w = 0; w < NWB; w++)
            ndec = ndec + DW'(wb_valid[w] && wb_addr[w*AW +: AW] == AW'(r));
        end
        sb_entry #(.CW(CW), .DW(DW)) u_e (
          .clk(clk), .reset(reset), .flush(flush), .inc(inc), .ndec(ndec),
          .cnt(cnt[r]), .uf(uf[r])
        );
      end
      if (r < NREG) begin : g_b
        assign busy_vec[r] = |cnt[r];
      end
    end
  endgenerate
`ifndef SB_FWD_EN
  logic fwd_unused;
  assign fwd_unused = ^{fwd_valid, fwd_addr};
`endif
  always_comb begin
    src_fwd_hit = '0;
    src_fwd_sel = '0;
    ok = '0;
    a = '0;
    m = 1'b0;
    h = 1'b0;
    ks = '0;
    for (int s = 0; s < NSRC; s++) begin
      a = iss_src_addr[s*AW +: AW];
      m = 1'b0;
      ks = '0;
`ifdef SB_FWD_EN
      // descending scan so the lowest matching port wins
      for (int k = NFWD - 1; k >= 0; k--)
        if (fwd_valid[k] && fwd_addr[k*AW +: AW] == a) begin
          m = 1'b1;
          ks = FW'(k);
        end
`endif
      h = iss_src_use[s] && a != '0 && cnt[a] == CW'(1) && m;
      ok[s] = !iss_src_use[s] || cnt[a] == '0 || h;
      src_fwd_hit[s] = h;
      src_fwd_sel[s*FW +: FW] = h ? ks : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) err_underflow <= 1'b0;
    else if (|uf) err_underflow <= 1'b1;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised register-hazard tracker for the decode stage; successor to fixed exe/mem/wb address-compare hazard logic.
- Keeps a per-register count of outstanding in-flight writes and lets the issue side check any number of source operands.
- Supports multi-cycle and out-of-order producers, several write-back (clear) ports and several forwarding ports.
- Sits beside the decode stage: decode presents sources and destination, the scoreboard returns issue-ready and forward selects.

Parameters:
- NREG, 32, number of architectural registers; register 0 is never tracked.
- AW, 5, register address width; requires 2**AW >= NREG.
- NSRC, 2, number of source operands checked per issue.
- NWB, 2, number of write-back/clear ports.
- NFWD, 3, number of forwarding ports; port 0 has highest priority.
- CW, 2, per-register counter width; saturation value MAXC = 2**CW-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  cancel all in-flight writers
- iss_valid  in  1  decode presents an instruction
- iss_ready  out  1  instruction may issue this cycle
- iss_src_use  in  NSRC  source s is read
- iss_src_addr  in  NSRC*AW  source addresses, s packed at [s*AW +: AW]
- iss_dst_we  in  1  instruction writes a register
- iss_dst_addr  in  AW  destination address
- wb_valid  in  NWB  write-back port w retires one write
- wb_addr  in  NWB*AW  write-back addresses
- fwd_valid  in  NFWD  forward port k holds a final result
- fwd_addr  in  NFWD*AW  forward addresses
- src_fwd_hit  out  NSRC  source s must take forwarded data
- src_fwd_sel  out  NSRC*max(1,$clog2(NFWD))  forward port index for source s
- busy_vec  out  NREG  bit r = (cnt[r] != 0)
- err_underflow  out  1  sticky: a write-back arrived for a counter already at 0

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset: all counters 0, err_underflow 0, so busy_vec 0 and iss_ready 1 (absent flush).
- Issue fires when iss_valid && iss_ready. An effective destination (iss_dst_we && iss_dst_addr!=0) increments cnt[dst].
- Latency: counter updates take effect the next cycle; there is no same-cycle wb-to-ready bypass.
- Source s is ok when any of:
  - !iss_src_use[s];
  - its address == 0;
  - cnt[a] == 0;
  - SB_FWD_EN defined, cnt[a] == 1, and some fwd_valid[k] with fwd_addr[k] == a.
- When cnt >= 2, source s stalls even if a forward port matches (the matching result could be stale).
- iss_ready = !flush && all sources ok && !(effective dst && cnt[dst] == MAXC). It is combinational and independent of iss_valid.
- Forward selection:
  - src_fwd_sel[s] is the lowest matching index k.
  - src_fwd_hit[s] = 1 only when s is used, its address != 0, cnt == 1 and a match exists.
  - Otherwise hit = 0 and sel = 0.
- Write-back: each wb_valid[w] with addr != 0 decrements cnt[addr] by 1. Several ports to the same register sum their decrements.
- Same register, same cycle: increment from issue and decrements from write-back apply together as net = cnt + inc - ndec.
- Underflow: if ndec > cnt + inc, the counter clamps to 0 and err_underflow sets (held until reset).
- Address 0 or address >= NREG on any port is ignored.
- Flush: all counters go to 0 next cycle. Flush overrides same-cycle issue and write-back; iss_ready = 0 while flush is high.
- Reset mid-operation: same as flush, and also clears err_underflow.

Optional Feature:
- Macro SB_FWD_EN.
- Defined: forwarding logic present as described.
- Undefined:
  - fwd_* inputs are ignored.
  - src_fwd_hit and src_fwd_sel are tied to 0.
  - A source is ok only when cnt == 0.

Decomposition:
- Package sb_pkg: AW, NREG, CW and MAXC localparams, plus a function for the forward-select width.
- Sub-module sb_entry, generated NREG-1 times (r = 1..NREG-1). Each instance holds one counter and takes inc, ndec and flush; it outputs cnt and an underflow pulse.
- Top level contains the address decoders, the per-source ok/forward mux and the sticky error flag.

Test Plan:
- Reset, then issue dst=5 and read src0=5 next cycle with no forward -> iss_ready=0, busy_vec[5]=1; wb_addr=5 -> iss_ready=1 the cycle after.
- cnt[7]=1 with fwd_valid={k1,k2} both addr 7 -> src_fwd_hit=1, sel=1; second issue to dst 7 (cnt=2) -> ready=0 despite forward match.
- Issue dst 3 and wb 3 in the same cycle with cnt[3]=1 -> cnt stays 1; both wb ports addr 3 with cnt=2 -> cnt=0.
- Three issues to dst 9 (CW=2, cnt reaches 3) -> a fourth issue writing 9 gets ready=0; write-back then frees it.
- wb addr 4 with cnt=0 -> err_underflow=1 and stays 1; flush with cnt[4..6]!=0 -> busy_vec=0 next cycle; reset clears err.
- Register 0 as source or destination -> never stalls, busy_vec[0] stays 0; build without SB_FWD_EN -> hit/sel stay 0, cnt=1 stalls.
